// File: rtl/data_mem_slave.sv
// data_mem_slave: responder for the core's data-memory port.
// Serves word reads/writes from an on-chip RAM and a 16-word MMIO window that
// holds a 64-bit machine timer (mtime/mtimecmp/timer_irq) and a tohost halt
// register. Reads are combinational. Writes, timer state and status flags are
// updated on the rising clock edge.
module data_mem_slave #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] MMIO_BASE  = 32'h0200_0000,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_re,
  input  logic [31:0] data_raddr,
  output logic [31:0] data_rdata,
  input  logic        data_we,
  input  logic [31:0] data_waddr,
  input  logic [31:0] data_wdata,
  output logic        timer_irq,
  output logic        halt,
  output logic [31:0] halt_code,
  output logic        bad_access
);

  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // MMIO word offsets within the 64-byte window (addr[5:2]).
  localparam logic [3:0] OFF_MTIME_LO = 4'h0;
  localparam logic [3:0] OFF_MTIME_HI = 4'h1;
  localparam logic [3:0] OFF_CMP_LO   = 4'h2;
  localparam logic [3:0] OFF_CMP_HI   = 4'h3;
  localparam logic [3:0] OFF_TOHOST   = 4'h4;

  logic [31:0]     mem_q [DEPTH];
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            timer_irq_q;
  logic            halt_q, halt_d;
  logic [31:0]     halt_code_q, halt_code_d;
  logic            bad_access_q;

  // Byte-lane bits are ignored: only whole words are addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_raddr[1:0], data_waddr[1:0]};

  // Address decode for both ports.
  logic                  r_ram_hit, r_mmio_hit, w_ram_hit, w_mmio_hit;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx;
  logic [3:0]            r_off, w_off;
  logic                  mmio_we;

  assign r_ram_hit  = (data_raddr[31:DEPTH_LOG2+2] == '0);
  assign w_ram_hit  = (data_waddr[31:DEPTH_LOG2+2] == '0);
  assign r_mmio_hit = (data_raddr[31:6] == MMIO_BASE[31:6]);
  assign w_mmio_hit = (data_waddr[31:6] == MMIO_BASE[31:6]);
  assign r_idx      = data_raddr[DEPTH_LOG2+1:2];
  assign w_idx      = data_waddr[DEPTH_LOG2+1:2];
  assign r_off      = data_raddr[5:2];
  assign w_off      = data_waddr[5:2];
  assign mmio_we    = data_we & w_mmio_hit;

  // Combinational read mux; returns 0 when idle or unmapped.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    data_rdata = '0;
    if (data_re) begin
      if (r_ram_hit) begin
        data_rdata = mem_q[r_idx];
      end else if (r_mmio_hit) begin
        case (r_off)
          OFF_MTIME_LO: data_rdata = mtime_q[31:0];
          OFF_MTIME_HI: data_rdata = mtime_q[63:32];
          OFF_CMP_LO:   data_rdata = mtimecmp_q[31:0];
          OFF_CMP_HI:   data_rdata = mtimecmp_q[63:32];
          OFF_TOHOST:   data_rdata = halt_code_q;
          default:      data_rdata = '0;
        endcase
      end
    end
  end

  // Next-state for timer, compare register and tohost latch.
  always_comb begin
    mtime_d     = mtime_q;
    presc_d     = presc_q;
    mtimecmp_d  = mtimecmp_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;

    // A CPU write to either mtime half wins over the tick and restarts the prescaler.
    if (mmio_we && (w_off == OFF_MTIME_LO)) begin
      mtime_d[31:0] = data_wdata;
      presc_d       = '0;
    end else if (mmio_we && (w_off == OFF_MTIME_HI)) begin
      mtime_d[63:32] = data_wdata;
      presc_d        = '0;
    end else if (presc_q == PRESC_LAST) begin
      mtime_d = mtime_q + 64'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (mmio_we && (w_off == OFF_CMP_LO)) mtimecmp_d[31:0]  = data_wdata;
    if (mmio_we && (w_off == OFF_CMP_HI)) mtimecmp_d[63:32] = data_wdata;

    // Only the first nonzero tohost write is captured; later writes are ignored.
    if (mmio_we && (w_off == OFF_TOHOST) && (data_wdata != '0) && !halt_q) begin
      halt_d      = 1'b1;
      halt_code_d = data_wdata;
    end
  end

  // Register state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q      <= '0;
      presc_q      <= '0;
      mtimecmp_q   <= '1;
      timer_irq_q  <= 1'b0;
      halt_q       <= 1'b0;
      halt_code_q  <= '0;
      bad_access_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      mtime_q      <= mtime_d;
      presc_q      <= presc_d;
      mtimecmp_q   <= mtimecmp_d;
      timer_irq_q  <= (mtime_q >= mtimecmp_q);
      halt_q       <= halt_d;
      halt_code_q  <= halt_code_d;
      bad_access_q <= (data_re & ~r_ram_hit & ~r_mmio_hit) |
                      (data_we & ~w_ram_hit & ~w_mmio_hit);
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset so it maps onto plain memory macros; contents survive rst_n.
    if (data_we && w_ram_hit) mem_q[w_idx] <= data_wdata;
  end

  assign timer_irq  = timer_irq_q;
  assign halt       = halt_q;
  assign halt_code  = halt_code_q;
  assign bad_access = bad_access_q;

endmodule
